// File: rtl/pdm_sample_feeder.sv
// Sample FIFO plus sample-rate divider feeding a signed PDM DAC input (IDLE/PRIME/PLAY/STARVED).
// Optional soft mute ramp while starved is compiled in with `define PDM_FEEDER_SOFT_MUTE_EN.
module pdm_sample_feeder #(
  parameter int unsigned SAMPLE_BITS = 12,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_BITS    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [DIV_BITS-1:0]           rate_div,
  input  logic                          s_valid,
  input  logic [SAMPLE_BITS-1:0]        s_data,
  output logic                          s_ready,
  input  logic                          underrun_clr,
  output logic [SAMPLE_BITS-1:0]        dac_din,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          playing,
  output logic                          underrun
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned HALF = FIFO_DEPTH / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    PLAY    = 2'd2,
    STARVED = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_BITS-1:0]     count_q, count_d;
  logic [DIV_BITS-1:0]     period_q, period_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [SAMPLE_BITS-1:0]  dac_q, dac_d;
  logic                    underrun_q, underrun_d;
  logic                    playing_q, playing_d;
  logic [SAMPLE_BITS-1:0]  mem_q [FIFO_DEPTH];

  logic                    push;
  logic                    pop;
  logic                    tick;
  logic                    running;
  logic                    primed;
  logic                    empty;
  logic                    underrun_set;

`ifdef PDM_FEEDER_SOFT_MUTE_EN
  localparam int unsigned MUTE_STEP = 2 ** (SAMPLE_BITS - 5);

  // One ramp step toward zero, clamped so the sign never flips.
  function automatic logic [SAMPLE_BITS-1:0] mute_step(input logic [SAMPLE_BITS-1:0] v);
    logic signed [SAMPLE_BITS-1:0] sv;
    logic signed [SAMPLE_BITS-1:0] st;
    sv = $signed(v);
    st = $signed(SAMPLE_BITS'(MUTE_STEP));
    if (sv > st) begin
      mute_step = SAMPLE_BITS'(sv - st);
    end else if (sv < -st) begin
      mute_step = SAMPLE_BITS'(sv + st);
    end else begin
      mute_step = '0;
    end
  endfunction
`endif

  assign s_ready = (level_q != LW'(FIFO_DEPTH));
  assign push    = s_valid & s_ready;
  assign running = (state_q == PLAY) || (state_q == STARVED);
  assign tick    = running && (count_q == period_q);
  assign primed  = (level_q >= LW'(HALF));
  assign empty   = (level_q == '0);

  assign dac_din  = dac_q;
  assign level    = level_q;
  assign playing  = playing_q;
  assign underrun = underrun_q;

  // Next-state, divider, FIFO bookkeeping and output computation.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_d     = period_q;
    dac_d        = dac_q;
    pop          = 1'b0;
    underrun_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        dac_d = '0;
        state_d = PRIME;
      end
      PRIME: begin
        if (primed) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (!empty) begin
            pop   = 1'b1;
            dac_d = mem_q[rd_ptr_q];
          end else begin
            underrun_set = 1'b1;
            state_d      = STARVED;
          end
        end
      end
      STARVED: begin
        if (primed) begin
          state_d = PLAY;
        end else if (tick) begin
          underrun_set = empty;
`ifdef PDM_FEEDER_SOFT_MUTE_EN
          dac_d = mute_step(dac_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Divider period only reloads at a tick, so a rate change never cuts a period short.
    if (running) begin
      if (tick) begin
        count_d  = '0;
        period_d = rate_div;
      end else begin
        count_d = count_q + DIV_BITS'(1);
      end
    end else begin
      count_d  = '0;
      period_d = rate_div;
    end

    if (!enable) begin
      state_d      = IDLE;
      dac_d        = '0;
      pop          = 1'b0;
      underrun_set = 1'b0;
      count_d      = '0;
    end

    underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    playing_d  = (state_d == PLAY);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dac_q      <= '0;
      underrun_q <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
      playing_q  <= playing_d;
    end
  end

  // Sample storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Randomized bench for pdm_sample_feeder against a queue-based behavioural model.
// Build with +define+PDM_FEEDER_SOFT_MUTE_EN to check the soft mute variant.
module tb_pdm_sample_feeder;

  localparam int DEPTH = 16;
  localparam int HALF  = 8;
  localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_STARVED = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [15:0] rd;
  logic        sv;
  logic [11:0] sd;
  logic        s_ready;
  logic        clr;
  logic [11:0] dac_din;
  logic [4:0]  level;
  logic        playing;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode, sample queue, absolute cycle of the next divider tick.
  int          m_mode;
  logic [11:0] m_q[$];
  logic [11:0] m_dac;
  logic        m_und;
  logic        m_play;
  int          cyc;
  int          next_tick;

  pdm_sample_feeder #(.SAMPLE_BITS(12), .FIFO_DEPTH(16), .DIV_BITS(16)) dut (
    .clk(clk), .resetn(resetn), .enable(en), .rate_div(rd),
    .s_valid(sv), .s_data(sd), .s_ready(s_ready), .underrun_clr(clr),
    .dac_din(dac_din), .level(level), .playing(playing), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode    = M_IDLE;
    m_dac     = '0;
    m_und     = 1'b0;
    m_play    = 1'b0;
    next_tick = 0;
  endtask

  // Apply one clock edge's worth of the playback rules to the model.
  task automatic model_edge();
    int  sz;
    int  nmode;
    int  v;
    bit  do_push;
    bit  is_tick;
    bit  set_und;
    sz      = m_q.size();
    do_push = sv && (sz != DEPTH);
    is_tick = (m_mode == M_PLAY || m_mode == M_STARVED) && (cyc == next_tick);
    set_und = 1'b0;
    nmode   = m_mode;
    if (!en) begin
      nmode = M_IDLE;
      m_dac = '0;
    end else begin
      case (m_mode)
        M_IDLE: nmode = M_PRIME;
        M_PRIME: begin
          if (sz >= HALF) begin
            nmode     = M_PLAY;
            next_tick = cyc + 1 + int'(rd);
          end
        end
        M_PLAY: begin
          if (is_tick) begin
            if (sz > 0) m_dac = m_q.pop_front();
            else begin
              set_und = 1'b1;
              nmode   = M_STARVED;
            end
          end
        end
        default: begin
          if (sz >= HALF) nmode = M_PLAY;
          else if (is_tick) begin
            if (sz == 0) set_und = 1'b1;
`ifdef PDM_FEEDER_SOFT_MUTE_EN
            v = $signed(m_dac);
            if (v > 128) v = v - 128;
            else if (v < -128) v = v + 128;
            else v = 0;
            m_dac = 12'(v);
`endif
          end
        end
      endcase
      if (is_tick) next_tick = cyc + 1 + int'(rd);
    end
    v = 0;
    m_und  = set_und ? 1'b1 : (clr ? 1'b0 : m_und);
    if (do_push) m_q.push_back(sd);
    m_mode = nmode;
    m_play = (nmode == M_PLAY);
    cyc++;
  endtask

  task automatic check_outputs(input string ph);
    check_eq({ph, ".level"},    32'(level),    32'(m_q.size()));
    check_eq({ph, ".s_ready"},  32'(s_ready),  32'(m_q.size() != DEPTH));
    check_eq({ph, ".dac_din"},  32'(dac_din),  32'(m_dac));
    check_eq({ph, ".playing"},  32'(playing),  32'(m_play));
    check_eq({ph, ".underrun"}, 32'(underrun), 32'(m_und));
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  // Asynchronous reset held across one clock edge; outputs checked before that edge.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    resetn = 1'b0; en = 1'b0; rd = '0; sv = 1'b0; sd = '0; clr = 1'b0;
    cyc = 0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Prime with 8 samples ending in 0x400, play at rate_div=3, then starve.
    for (int i = 0; i < 8; i++) begin
      sv = 1'b1;
      sd = (i == 7) ? 12'h400 : 12'($urandom);
      step("fill8");
    end
    sv = 1'b0; rd = 16'd3; en = 1'b1;
    repeat (45) step("play8");
    for (int i = 0; i < 16; i++) begin
      clr = (i % 3 == 0);
      step("uclr");
    end
    clr = 1'b0;
    repeat (30) step("starve");
`ifdef PDM_FEEDER_SOFT_MUTE_EN
    check_eq("starve_dac", 32'(dac_din), 32'h0);
`else
    check_eq("starve_dac", 32'(dac_din), 32'h400);
`endif
    check_eq("starve_und",  32'(underrun), 32'h1);
    check_eq("starve_play", 32'(playing),  32'h0);

    // Fill to full with s_valid held, then push and pop together at level 10.
    en = 1'b0;
    step("stop");
    for (int i = 0; i < 20; i++) begin
      sv = 1'b1;
      sd = 12'($urandom);
      step("full");
    end
    check_eq("full_lvl", 32'(level),   32'd16);
    check_eq("full_rdy", 32'(s_ready), 32'h0);
    sv = 1'b0; rd = 16'd0; en = 1'b1;
    n = 0;
    while (m_q.size() > 10 && n < 100) begin
      step("drain");
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      sv = 1'b1;
      sd = 12'($urandom);
      step("pushpop");
    end
    check_eq("pushpop_lvl", 32'(level), 32'd10);

    // Rate change 9 -> 2 in mid period.
    sv = 1'b0; en = 1'b0;
    step("stop2");
    rd = 16'd9; en = 1'b1;
    repeat (6) step("rate9");
    rd = 16'd2;
    repeat (30) step("rate2");

    // Randomized traffic with varying producer duty cycle.
    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < 200; i++) begin
        en  = ($urandom % 64) != 0;
        sv  = ($urandom % 8) < (b % 4) * 2 + 1;
        sd  = 12'($urandom);
        clr = ($urandom % 8) == 0;
        if ($urandom % 16 == 0) rd = 16'($urandom % 4);
        step("rand");
      end
    end
    clr = 1'b0; sv = 1'b0;

    // Reset in mid playback at level 5, then a fresh push after release.
    en = 1'b0;
    step("stop3");
    do_reset();
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      sv = 1'b1;
      sd = 12'($urandom);
      step("fill_r");
    end
    sv = 1'b0; rd = 16'd3; en = 1'b1;
    n = 0;
    while (m_q.size() > 5 && n < 200) begin
      step("to5");
      n++;
    end
    check_eq("lvl5",  32'(level),   32'd5);
    check_eq("play5", 32'(playing), 32'h1);
    en = 1'b0;
    do_reset();
    check_eq("post_rst_lvl", 32'(level), 32'd0);
    sv = 1'b1;
    sd = 12'h123;
    step("push_after_rst");
    sv = 1'b0;
    step("idle_after_rst");
    check_eq("post_rst_push", 32'(level), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_sample_feeder.md
PDM_SAMPLE_FEEDER -- requirements
Module: pdm_sample_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 12, signed sample width matching the downstream PDM DAC din.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter DIV_BITS, default 16, width of the sample-rate divider.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  playback enable.
REQ-007 SHALL have port rate_div  input  DIV_BITS  sample period minus one, in clk cycles.
REQ-008 SHALL have port s_valid  input  1  producer sample valid.
REQ-009 SHALL have port s_data  input  SAMPLE_BITS  producer sample, signed two's complement.
REQ-010 SHALL have port s_ready  output  1  FIFO can accept a sample.
REQ-011 SHALL have port underrun_clr  input  1  clears the sticky underrun flag.
REQ-012 SHALL have port dac_din  output  SAMPLE_BITS  signed sample to the PDM DAC; registered.
REQ-013 SHALL have port level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port playing  output  1  high only in state PLAY.
REQ-015 SHALL have port underrun  output  1  sticky flag: a tick found the FIFO empty.

Function
REQ-016 SHALL accept a push when s_valid and s_ready are both high on a clock edge; s_ready = (level != FIFO_DEPTH), combinational from level.
REQ-017 SHALL leave level unchanged on a simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-018 SHALL run the divider only in PLAY or STARVED: count 0..rate_div, tick when count == rate_div, then reload 0; one tick every rate_div+1 cycles; rate_div=0 gives a tick every cycle.
REQ-019 SHALL sample a rate_div change only on the cycle of the reload, so the current period is never truncated.
REQ-020 SHALL implement states IDLE, PRIME, PLAY and STARVED.
REQ-021 IDLE: divider held at 0, dac_din driven 0 (DAC midscale); enable=1 moves to PRIME on the next edge.
REQ-022 PRIME: no pops; moves to PLAY when level >= FIFO_DEPTH/2; the divider starts at count 0 on entry to PLAY.
REQ-023 PLAY: on a tick with level>0, pop head and load it into dac_din on the same edge (dac_din valid 1 cycle after the tick cycle); on a tick with level==0, set underrun and move to STARVED.
REQ-024 STARVED: divider keeps running; each tick with level==0 sets underrun; moves to PLAY on the edge where level >= FIFO_DEPTH/2; no pop on that edge.
REQ-025 SHALL move to IDLE from any state on the edge where enable=0, with dac_din=0 on that edge; FIFO contents and underrun are retained.
REQ-026 SHALL, if underrun_clr and an underrun-setting tick occur together, leave underrun set.
REQ-027 SHALL push into the FIFO in every state, including IDLE.
REQ-028 SHALL, with the macro absent, hold dac_din at its last value while STARVED.

Reset
REQ-029 SHALL, on resetn low, asynchronously force: state IDLE, divider 0, FIFO pointers 0 (level 0), dac_din 0, underrun 0, playing 0, s_ready 1.
REQ-030 SHALL, on reset asserted mid-playback, discard all FIFO contents; first push after release is accepted at level 0.

Configuration
REQ-031 SHALL compile soft muting when macro PDM_FEEDER_SOFT_MUTE_EN is defined: each STARVED tick moves dac_din toward 0 by 2^(SAMPLE_BITS-5), clamped at 0 without overshoot or sign change.
REQ-032 SHALL, without PDM_FEEDER_SOFT_MUTE_EN, implement no ramp logic; behaviour per REQ-028.

Verification
REQ-033 SHALL cover: reset, push 8 samples, enable=1, rate_div=3 -> PRIME until level=8, PLAY, pops every 4 cycles, dac_din follows the pushed sequence 1 cycle after each tick.
REQ-034 SHALL cover: push 16 samples with s_valid held high -> s_ready low at level=16; 17th sample not accepted; simultaneous push and pop at level=10 -> level stays 10.
REQ-035 SHALL cover: PLAY with no refill, last sample 0x400 -> next tick sets underrun, state STARVED, dac_din stays 0x400 (macro off) or steps 0x380, 0x300... to 0 (macro on, SAMPLE_BITS=12).
REQ-036 SHALL cover: underrun_clr pulsed on the same cycle as a STARVED tick -> underrun remains 1; pulsed alone -> underrun 0 next edge.
REQ-037 SHALL cover: rate_div changed 9 -> 2 mid-period -> current period completes at 10 cycles, following periods 3 cycles.
REQ-038 SHALL cover: resetn low for 1 cycle during PLAY at level 5 -> immediate level 0, dac_din 0, state IDLE, underrun 0.
